// File: rtl/menu_pkg.sv
// Shared scan codes, FSM state type and option-count helper for the menu navigation controller.
package menu_pkg;

  localparam logic [7:0] KeyUp    = 8'h75;
  localparam logic [7:0] KeyDown  = 8'h72;
  localparam logic [7:0] KeyLeft  = 8'h6B;
  localparam logic [7:0] KeyRight = 8'h74;
  localparam logic [7:0] KeyEnter = 8'h5A;
  localparam logic [7:0] KeyEsc   = 8'h76;
  localparam logic [7:0] KeyBreak = 8'hF0;
  localparam logic [7:0] KeyExt   = 8'hE0;

  // Upper bound on items the count helper can address.
  localparam int unsigned MaxItems = 32;
  localparam int unsigned CountsW  = 8 * MaxItems;

  typedef enum logic [1:0] {
    StBrowse,
    StEdit,
    StView
  } menu_state_e;

  // Option count of item idx; 0 marks a full-screen view item.
  function automatic logic [7:0] item_count(input logic [CountsW-1:0] counts,
                                            input int unsigned idx);
    return counts[8*idx +: 8];
  endfunction

endpackage

// File: rtl/ps2_key_event.sv
// Turns raw PS/2 bytes into press events: E0 prefixes pass through, F0 swallows the next byte.
module ps2_key_event
  import menu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic       press_valid,
  output logic [7:0] press_code
);

  logic break_q, break_d;

  always_comb begin
    break_d = break_q;
    if (key_valid) begin
      if (key_code == KeyBreak) begin
        break_d = 1'b1;
      end else if (key_code != KeyExt) begin
        // The byte after F0 is the released key; consume it and clear.
        break_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      break_q <= 1'b0;
    end else begin
      break_q <= break_d;
    end
  end

  assign press_valid = key_valid && (key_code != KeyBreak) && (key_code != KeyExt) && !break_q;
  assign press_code  = key_code;

endmodule

// File: rtl/menu_nav_ctrl.sv
// Menu cursor / option-edit / view-mode controller driven by PS/2 press events.
// Define MENU_WRAP_EN to make cursor and option steps wrap instead of saturate.
module menu_nav_ctrl
  import menu_pkg::*;
#(
  parameter int unsigned                 NUM_ITEMS  = 4,
  parameter int unsigned                 MAX_OPTS   = 5,
  parameter logic [8*NUM_ITEMS-1:0]      OPT_COUNTS = 32'h02_05_02_00,
  parameter int unsigned                 ITEM_W     = $clog2(NUM_ITEMS),
  parameter int unsigned                 OPT_W      = $clog2(MAX_OPTS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 key_code,
  input  logic                       key_valid,
  output logic [ITEM_W-1:0]          cursor,
  output logic                       editing,
  output logic                       view_mode,
  output logic [NUM_ITEMS*OPT_W-1:0] opt_sel,
  output logic                       opt_update,
  output logic [ITEM_W-1:0]          upd_item
);

`ifdef MENU_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  localparam logic [CountsW-1:0] CountsExt = CountsW'(OPT_COUNTS);
  localparam logic [ITEM_W-1:0]  LastItem  = ITEM_W'(NUM_ITEMS - 1);

  if (NUM_ITEMS < 2 || NUM_ITEMS > MaxItems) begin : g_bad_items
    $error("menu_nav_ctrl: NUM_ITEMS out of range");
  end
  if (MAX_OPTS < 2) begin : g_bad_opts
    $error("menu_nav_ctrl: MAX_OPTS must be at least 2");
  end

  logic        press_valid;
  logic [7:0]  press_code;

  ps2_key_event u_key_event (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .press_valid (press_valid),
    .press_code  (press_code)
  );

  menu_state_e       state_q, state_d;
  logic [ITEM_W-1:0] cursor_q, cursor_d;
  logic [OPT_W-1:0]  opt_sel_q [NUM_ITEMS];
  logic [OPT_W-1:0]  opt_sel_d [NUM_ITEMS];
  logic              opt_update_q, opt_update_d;
  logic [ITEM_W-1:0] upd_item_q, upd_item_d;

  logic [OPT_W-1:0]  max_opt [NUM_ITEMS];
  logic              is_view [NUM_ITEMS];

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_items
    localparam logic [7:0] Cnt = item_count(CountsExt, i);
    if (Cnt > MAX_OPTS || (Cnt != 0 && (int'(Cnt) - 1) >= (1 << OPT_W))) begin : g_bad_cnt
      $error("menu_nav_ctrl: option count does not fit OPT_W");
    end
    assign is_view[i] = (Cnt == 8'd0);
    assign max_opt[i] = (Cnt == 8'd0) ? '0 : OPT_W'(Cnt - 8'd1);
    assign opt_sel[i*OPT_W +: OPT_W] = opt_sel_q[i];
  end

  logic [OPT_W-1:0] cur_opt, cur_max, opt_inc, opt_dec;

  always_comb begin
    cur_opt = opt_sel_q[cursor_q];
    cur_max = max_opt[cursor_q];
    opt_inc = (cur_opt == cur_max) ? (WrapEn ? '0 : cur_max) : cur_opt + OPT_W'(1);
    opt_dec = (cur_opt == '0) ? (WrapEn ? cur_max : '0) : cur_opt - OPT_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_q;
    opt_sel_d    = opt_sel_q;
    opt_update_d = 1'b0;
    upd_item_d   = upd_item_q;

    if (press_valid) begin
      case (state_q)
        StBrowse: begin
          if (press_code == KeyUp) begin
            if (cursor_q != '0) begin
              cursor_d = cursor_q - ITEM_W'(1);
            end else if (WrapEn) begin
              cursor_d = LastItem;
            end
          end else if (press_code == KeyDown) begin
            if (cursor_q != LastItem) begin
              cursor_d = cursor_q + ITEM_W'(1);
            end else if (WrapEn) begin
              cursor_d = '0;
            end
          end else if (press_code == KeyEnter) begin
            state_d = is_view[cursor_q] ? StView : StEdit;
          end
        end

        StEdit: begin
          if (press_code == KeyRight || press_code == KeyLeft) begin
            opt_sel_d[cursor_q] = (press_code == KeyRight) ? opt_inc : opt_dec;
            // Saturated steps leave the value alone and must not pulse.
            if (opt_sel_d[cursor_q] != cur_opt) begin
              opt_update_d = 1'b1;
              upd_item_d   = cursor_q;
            end
          end else if (press_code == KeyEsc || press_code == KeyEnter) begin
            state_d = StBrowse;
          end
        end

        StView: begin
          if (press_code == KeyEsc) begin
            state_d = StBrowse;
          end
        end

        default: state_d = StBrowse;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StBrowse;
      cursor_q     <= '0;
      opt_sel_q    <= '{default: '0};
      opt_update_q <= 1'b0;
      upd_item_q   <= '0;
    end else begin
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      opt_sel_q    <= opt_sel_d;
      opt_update_q <= opt_update_d;
      upd_item_q   <= upd_item_d;
    end
  end

  assign cursor     = cursor_q;
  assign editing    = (state_q == StEdit);
  assign view_mode  = (state_q == StView);
  assign opt_update = opt_update_q;
  assign upd_item   = upd_item_q;

endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Randomised and directed bench for menu_nav_ctrl against a behavioural menu model.
module tb_menu_nav_ctrl;

  localparam int NI = 4;
  localparam int OW = 3;
  localparam int IW = 2;

`ifdef MENU_WRAP_EN
  localparam bit Wrap = 1'b1;
`else
  localparam bit Wrap = 1'b0;
`endif

  localparam logic [7:0] KUp = 8'h75, KDown = 8'h72, KLeft = 8'h6B, KRight = 8'h74;
  localparam logic [7:0] KEnter = 8'h5A, KEsc = 8'h76, KBrk = 8'hF0, KExt = 8'hE0;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        key_code = 8'h00;
  logic              key_valid = 1'b0;
  logic [IW-1:0]     cursor, upd_item;
  logic              editing, view_mode, opt_update;
  logic [NI*OW-1:0]  opt_sel;

  menu_nav_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .cursor     (cursor),
    .editing    (editing),
    .view_mode  (view_mode),
    .opt_sel    (opt_sel),
    .opt_update (opt_update),
    .upd_item   (upd_item)
  );

  always #5 clk = ~clk;

  // Model: mode 0 browse, 1 edit, 2 view.
  int cnt [NI] = '{0, 2, 5, 2};
  int m_cursor, m_mode, m_upd, m_upd_item;
  int m_opt [NI];
  bit m_brk;
  bit chk_en = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cursor = 0; m_mode = 0; m_upd = 0; m_upd_item = 0; m_brk = 1'b0;
    for (int i = 0; i < NI; i++) m_opt[i] = 0;
  endtask

  task automatic model_step(input logic [7:0] c, input bit v);
    int n;
    m_upd = 0;
    if (!v || c == KExt) return;
    if (c == KBrk) begin m_brk = 1'b1; return; end
    if (m_brk) begin m_brk = 1'b0; return; end
    if (m_mode == 0) begin
      if (c == KUp) m_cursor = (m_cursor > 0) ? m_cursor - 1 : (Wrap ? NI - 1 : 0);
      else if (c == KDown) m_cursor = (m_cursor < NI - 1) ? m_cursor + 1 : (Wrap ? 0 : NI - 1);
      else if (c == KEnter) m_mode = (cnt[m_cursor] == 0) ? 2 : 1;
    end else if (m_mode == 1) begin
      if (c == KRight || c == KLeft) begin
        if (c == KRight) begin
          n = m_opt[m_cursor] + 1;
          if (n >= cnt[m_cursor]) n = Wrap ? 0 : cnt[m_cursor] - 1;
        end else begin
          n = m_opt[m_cursor] - 1;
          if (n < 0) n = Wrap ? cnt[m_cursor] - 1 : 0;
        end
        if (n != m_opt[m_cursor]) begin
          m_opt[m_cursor] = n; m_upd = 1; m_upd_item = m_cursor;
        end
      end else if (c == KEsc || c == KEnter) begin
        m_mode = 0;
      end
    end else if (c == KEsc) begin
      m_mode = 0;
    end
  endtask

  function automatic logic [NI*OW-1:0] exp_opt_sel();
    logic [NI*OW-1:0] r;
    for (int i = 0; i < NI; i++) r[i*OW +: OW] = OW'(m_opt[i]);
    return r;
  endfunction

  function automatic int dut_opt(input int i);
    return int'(opt_sel[i*OW +: OW]);
  endfunction

  task automatic send(input logic [7:0] c, input bit v = 1'b1);
    @(negedge clk);
    key_code  = c;
    key_valid = v;
    @(posedge clk);
    model_step(c, v);
    #1 key_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cursor", 32'(cursor), m_cursor);
      chk("editing", 32'(editing), 32'(m_mode == 1));
      chk("view_mode", 32'(view_mode), 32'(m_mode == 2));
      chk("opt_sel", 32'(opt_sel), 32'(exp_opt_sel()));
      chk("opt_update", 32'(opt_update), m_upd);
      if (m_upd != 0) chk("upd_item", 32'(upd_item), m_upd_item);
    end
  end

  initial begin
    int pulses;
    int r;
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cursor", 32'(cursor), 0);
    chk("rst_editing", 32'(editing), 0);
    chk("rst_view", 32'(view_mode), 0);
    chk("rst_opt_sel", 32'(opt_sel), 0);
    chk("rst_opt_update", 32'(opt_update), 0);
    chk("rst_upd_item", 32'(upd_item), 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Two DOWN presses.
    send(KDown); send(KDown);
    chk("t1_cursor", 32'(cursor), 2);
    chk("t1_no_update", 32'(opt_update), 0);

    // Edit item 2 and step right five times.
    send(KEnter);
    chk("t2_editing", 32'(editing), 1);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      send(KRight);
      chk("t2_opt", dut_opt(2), (k < 4) ? k + 1 : (Wrap ? 0 : 4));
      chk("t2_pulse", 32'(opt_update), (k < 4) ? 1 : 32'(Wrap));
      if (k == 0) chk("t2_upd_item", 32'(upd_item), 2);
      pulses += int'(opt_update);
    end
    chk("t2_pulse_count", pulses, Wrap ? 5 : 4);

    // Leave, move up, edit item 1 and press LEFT at option 0.
    send(KEsc);
    chk("t3_editing_off", 32'(editing), 0);
    send(KUp);
    chk("t3_cursor", 32'(cursor), 1);
    send(KEnter);
    chk("t3_editing_on", 32'(editing), 1);
    send(KLeft);
    chk("t3_opt1", dut_opt(1), Wrap ? 1 : 0);
    chk("t3_opt2", dut_opt(2), Wrap ? 0 : 4);
    send(KEsc);

    // View item: a released ESC must not leave view.
    send(KUp);
    chk("t4_cursor0", 32'(cursor), 0);
    send(KEnter);
    chk("t4_view_on", 32'(view_mode), 1);
    send(KBrk); send(KEsc);
    chk("t4_view_held", 32'(view_mode), 1);
    send(KEsc);
    chk("t4_view_off", 32'(view_mode), 0);
    chk("t4_cursor", 32'(cursor), 0);

    // Extended prefix is transparent; a break sequence is not a press.
    send(KExt); send(KDown);
    chk("t5_ext_down", 32'(cursor), 1);
    send(KBrk); send(KDown);
    chk("t5_break_down", 32'(cursor), 1);

    // Boundary at the top of the list.
    send(KUp);
    send(KUp);
    chk("t6_up_at_top", 32'(cursor), Wrap ? 3 : 0);

    // Async reset in the middle of an edit, with a break pending.
    for (int k = 0; k < 4 && m_cursor != 2; k++) send((m_cursor < 2) ? KDown : KUp);
    send(KEnter);
    send(KRight);
    send(KBrk);
    #2;
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_cursor", 32'(cursor), 0);
    chk("t6_rst_editing", 32'(editing), 0);
    chk("t6_rst_opt_sel", 32'(opt_sel), 0);
    chk("t6_rst_update", 32'(opt_update), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    send(KDown);
    chk("t6_break_cleared", 32'(cursor), 1);

    // Random byte stream.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      send(8'(($urandom)), 1'b0);
      else if (r < 17) send(KExt);
      else if (r < 25) send(KBrk);
      else if (r < 33) send(8'($urandom));
      else begin
        case ($urandom_range(0, 5))
          0: send(KUp);
          1: send(KDown);
          2: send(KLeft);
          3: send(KRight);
          4: send(KEnter);
          default: send(KEsc);
        endcase
      end
    end
    send(8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
